// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the burst arbiter and its round-robin picker.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Index width for n items, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_burst_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, cyclically.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               any_o,
    output logic [ID_W-1:0]    winner_o
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner.
    assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        any_o = |rot;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
        sum      = {1'b0, ptr_i} + {1'b0, off};
        winner_o = (sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(sum - (ID_W + 1)'(NUM_REQ))
                                                 : sum[ID_W-1:0];
    end

endmodule

// File: rtl/ram_burst_arbiter.sv
// Round-robin grant of byte bursts from a combinational-read memory; streams
// registered bytes tagged with the owning requester.
module ram_burst_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      rd_last,
    output logic [ID_W-1:0]           rd_id,
    output logic                      busy
);

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  len_arr;

    assign addr_arr = req_addr;
    assign len_arr  = req_len;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [ID_W-1:0]     rd_id_q, rd_id_d;

    logic                any;
    logic [ID_W-1:0]     win;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .any_o    (any),
        .winner_o (win)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_id_d   = cur_id_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        gnt_d      = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_id_d    = rd_id_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    gnt_d    = NUM_REQ'(1) << win;
                    addr_d   = addr_arr[win];
                    rem_d    = len_arr[win];
                    cur_id_d = win;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                rd_data_d  = mem_data;
                rd_valid_d = 1'b1;
                rd_id_d    = cur_id_q;
                rd_last_d  = (rem_q == '0);
                addr_d     = addr_q + ADDR_W'(1);
                rem_d      = rem_q - LEN_W'(1);
                // The just-served requester drops to lowest priority.
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    ptr_d   = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cur_id_q   <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            gnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_id_q   <= cur_id_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            gnt_q      <= gnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign mem_addr = addr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_id    = rd_id_q;
    assign busy     = (state_q == ST_BURST);

endmodule
